// File: rtl/ctrl_unit_hs.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_unit_hs
// Description : Multi-cycle control unit for the bus-based processor with FPU.
//               Fetches over a req/ack memory handshake, decodes {opc,RX,RY}
//               and sequences one-hot register-file and datapath strobes.
//               Wait states optionally abort after WAIT_MAX cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_unit_hs #(
    parameter int DATA_W   = 9,
    parameter int REG_AW   = 3,
    parameter int OPC_W    = 3,
    parameter int WAIT_MAX = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [DATA_W-1:0]                 din,
    input  logic                              mem_ack,
    input  logic                              fpu_done,
    input  logic                              g_nz,
    output logic [OPC_W+2*REG_AW-1:0]         ir,
    output logic [4:0]                        state,
    output logic [(1<<REG_AW)-1:0]            reg_in,
    output logic [(1<<REG_AW)-1:0]            reg_out,
    output logic                              din_out,
    output logic                              g_out,
    output logic                              gf_out,
    output logic                              a_in,
    output logic                              g_in,
    output logic                              af_in,
    output logic                              gf_in,
    output logic                              add_sub,
    output logic                              fpu_start,
    output logic                              addr_in,
    output logic                              dout_in,
    output logic                              mem_rd,
    output logic                              mem_wr,
    output logic                              incr_pc,
    output logic                              done,
    output logic                              illegal_op,
    output logic                              timeout_err
);

    localparam int INSTR_W = OPC_W + 2 * REG_AW;
    localparam int NREGS   = 1 << REG_AW;
    localparam int PC_IDX  = NREGS - 1;
    localparam int CNT_W   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    // Count value seen in the last permitted wait cycle (count starts at 0)
    localparam logic [CNT_W-1:0] TMO_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;

    typedef enum logic [4:0] {
        ST_RESET  = 5'd0,  ST_LDADDR = 5'd1,  ST_FWAIT = 5'd2,  ST_DECODE = 5'd3,
        ST_MV     = 5'd4,  ST_MVI_A  = 5'd5,  ST_MVI_W = 5'd6,  ST_AS1    = 5'd7,
        ST_AS2    = 5'd8,  ST_AS3    = 5'd9,  ST_LD1   = 5'd10, ST_LDW    = 5'd11,
        ST_ST1    = 5'd12, ST_ST2    = 5'd13, ST_STW   = 5'd14, ST_MVNZ   = 5'd15,
        ST_F1     = 5'd16, ST_F2     = 5'd17, ST_FW    = 5'd18, ST_TRAP   = 5'd19
    } state_t;

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [OPC_W-1:0]     opc;
    logic [31:0]          opc_ext;
    logic [REG_AW-1:0]    rx;
    logic [REG_AW-1:0]    ry;
    logic                 wait_expired;

    assign opc          = ir_q[INSTR_W-1 -: OPC_W];
    assign opc_ext      = 32'(opc);
    assign rx           = ir_q[2*REG_AW-1 -: REG_AW];
    assign ry           = ir_q[REG_AW-1:0];
    assign wait_expired = (WAIT_MAX > 0) && (cnt_q == TMO_LAST);
    assign state        = state_q;
    assign ir           = ir_q;

    // State, instruction and wait-counter registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_RESET;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode; wait states count while no ack, else counter is held at 0
    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        cnt_d       = '0;
        reg_in      = '0;
        reg_out     = '0;
        din_out     = 1'b0;
        g_out       = 1'b0;
        gf_out      = 1'b0;
        a_in        = 1'b0;
        g_in        = 1'b0;
        af_in       = 1'b0;
        gf_in       = 1'b0;
        add_sub     = 1'b0;
        fpu_start   = 1'b0;
        addr_in     = 1'b0;
        dout_in     = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        incr_pc     = 1'b0;
        done        = 1'b0;
        illegal_op  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ST_RESET: state_d = ST_LDADDR;
            ST_LDADDR: begin
                reg_out[PC_IDX] = 1'b1;
                addr_in         = 1'b1;
                mem_rd          = 1'b1;
                state_d         = ST_FWAIT;
            end
            ST_FWAIT: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    ir_d    = din[INSTR_W-1:0];
                    incr_pc = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    done        = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = ST_LDADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECODE: begin
                case (opc_ext)
                    32'd0:        state_d = ST_MV;
                    32'd1:        state_d = ST_MVI_A;
                    32'd2, 32'd3: state_d = ST_AS1;
                    32'd4:        state_d = ST_LD1;
                    32'd5:        state_d = ST_ST1;
                    32'd6:        state_d = ST_MVNZ;
                    32'd7:        state_d = ST_F1;
                    default:      state_d = ST_TRAP;
                endcase
            end
            ST_MV: begin
                reg_out[ry] = 1'b1;
                reg_in[rx]  = 1'b1;
                done        = 1'b1;
                state_d     = ST_LDADDR;
            end
            ST_MVI_A: begin
                reg_out[PC_IDX] = 1'b1;
                addr_in         = 1'b1;
                mem_rd          = 1'b1;
                state_d         = ST_MVI_W;
            end
            ST_MVI_W: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    din_out    = 1'b1;
                    reg_in[rx] = 1'b1;
                    incr_pc    = 1'b1;
                    done       = 1'b1;
                    state_d    = ST_LDADDR;
                end else if (wait_expired) begin
                    done        = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = ST_LDADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_AS1: begin
                reg_out[rx] = 1'b1;
                a_in        = 1'b1;
                state_d     = ST_AS2;
            end
            ST_AS2: begin
                reg_out[ry] = 1'b1;
                g_in        = 1'b1;
                add_sub     = (opc_ext == 32'd3);
                state_d     = ST_AS3;
            end
            ST_AS3: begin
                g_out      = 1'b1;
                reg_in[rx] = 1'b1;
                done       = 1'b1;
                state_d    = ST_LDADDR;
            end
            ST_LD1: begin
                reg_out[ry] = 1'b1;
                addr_in     = 1'b1;
                mem_rd      = 1'b1;
                state_d     = ST_LDW;
            end
            ST_LDW: begin
                mem_rd = 1'b1;
                if (mem_ack) begin
                    din_out    = 1'b1;
                    reg_in[rx] = 1'b1;
                    done       = 1'b1;
                    state_d    = ST_LDADDR;
                end else if (wait_expired) begin
                    done        = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = ST_LDADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ST1: begin
                reg_out[rx] = 1'b1;
                dout_in     = 1'b1;
                state_d     = ST_ST2;
            end
            ST_ST2: begin
                reg_out[ry] = 1'b1;
                addr_in     = 1'b1;
                state_d     = ST_STW;
            end
            ST_STW: begin
                mem_wr = 1'b1;
                if (mem_ack) begin
                    done    = 1'b1;
                    state_d = ST_LDADDR;
                end else if (wait_expired) begin
                    done        = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = ST_LDADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MVNZ: begin
                if (g_nz) begin
                    state_d = ST_MV;
                end else begin
                    done    = 1'b1;
                    state_d = ST_LDADDR;
                end
            end
            ST_F1: begin
                reg_out[rx] = 1'b1;
                af_in       = 1'b1;
                state_d     = ST_F2;
            end
            ST_F2: begin
                reg_out[ry] = 1'b1;
                gf_in       = 1'b1;
                fpu_start   = 1'b1;
                state_d     = ST_FW;
            end
            ST_FW: begin
                if (fpu_done) begin
                    gf_out     = 1'b1;
                    reg_in[rx] = 1'b1;
                    done       = 1'b1;
                    state_d    = ST_LDADDR;
                end else if (wait_expired) begin
                    done        = 1'b1;
                    timeout_err = 1'b1;
                    state_d     = ST_LDADDR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TRAP: begin
                done       = 1'b1;
                illegal_op = 1'b1;
                state_d    = ST_LDADDR;
            end
            default: state_d = ST_RESET;
        endcase
    end

endmodule
`default_nettype wire
